// File: rtl/mult_div_unit.sv
// Iterative 32-bit MIPS multiply/divide unit with architectural HI/LO.
// Shift-add multiply and restoring divide on operand magnitudes, 32 iterations plus one fix-up cycle.
module mult_div_unit (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        kill,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic [31:0] wdat,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, sa_q, sb_q, divz_q;
  logic [31:0] opa_q, m_q;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic        start_ok;
  logic        sa_in, sb_in;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem;
  logic [63:0] prod_fix;
  logic [31:0] res_hi, res_lo;

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  assign start_ok = (state_q == IDLE) && start && !kill;
  assign sa_in    = ~op[0] & opa[31];
  assign sb_in    = ~op[0] & opb[31];
  assign mag_a    = cneg32(opa, sa_in);
  assign mag_b    = cneg32(opb, sb_in);

  // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
    div_shift = acc_q[63:31];
    div_ge    = (div_shift >= {1'b0, m_q});
    div_rem   = div_ge ? 32'(div_shift - {1'b0, m_q}) : div_shift[31:0];
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (start_ok) begin
      cnt_d = 5'd0;
      acc_d = {32'd0, op[1] ? mag_a : mag_b};
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 5'd1;
      acc_d = is_div_q ? {div_rem, acc_q[30:0], div_ge} : {mul_sum, acc_q[31:1]};
    end
  end

  // Sign fix-up; divide by zero bypasses the algorithm's raw output
  always_comb begin
    prod_fix = cneg64(acc_q, sa_q ^ sb_q);
    res_hi   = prod_fix[63:32];
    res_lo   = prod_fix[31:0];
    if (is_div_q) begin
      if (divz_q) begin
        res_hi = opa_q;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = cneg32(acc_q[63:32], sa_q);
        res_lo = cneg32(acc_q[31:0], sa_q ^ sb_q);
      end
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == IDLE) begin
      if (hi_wen) hi_d = wdat;
      if (lo_wen) lo_d = wdat;
    end else if ((state_q == FIX) && !kill) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (kill) state_d = IDLE;
               else if (cnt_q == 5'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != IDLE);
    done_d = (state_q == FIX) && !kill;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      divz_q   <= 1'b0;
      opa_q    <= 32'd0;
      m_q      <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      if (start_ok) begin
        is_div_q <= op[1];
        sa_q     <= sa_in;
        sb_q     <= sb_in;
        divz_q   <= op[1] && (opb == 32'd0);
        opa_q    <= opa;
        m_q      <= op[1] ? mag_b : mag_a;
      end
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table issued back-to-back through a scoreboard,
// plus hand-written kill, stall-ignore, write/start overlap and async-reset sequences.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        n_rst, start, kill, hi_wen, lo_wen;
  logic [1:0]  op;
  logic [31:0] opa, opb, wdat;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] l;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[13];

  mult_div_unit dut (
    .clk(clk), .n_rst(n_rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .kill(kill), .hi_wen(hi_wen), .lo_wen(lo_wen), .wdat(wdat),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input bit push);
    exp_t e;
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    if (push) begin
      e.h = eh;
      e.l = el;
      sb_q.push_back(e);
    end
    tick();
    start = 1'b0;
    opa   = $urandom;
    opb   = $urandom;
  endtask

  task automatic wait_done(input int n0, input string tag);
    int n;
    exp_t e;
    n = n0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", tag);
    end else begin
      chk({tag, "_latency"}, 32'(n), 32'd34);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_scoreboard actual=done required=no_pending", tag);
      end else begin
        e = sb_q.pop_front();
        chk({tag, "_hi"}, hi, e.h);
        chk({tag, "_lo"}, lo, e.l);
      end
    end
  endtask

  initial begin
    int seen;
    vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{2'b11, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
    vecs[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[5]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[6]  = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3};
    vecs[7]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[8]  = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{2'b01, 32'h12345678, 32'h10,       32'd1,        32'h23456780};
    vecs[10] = '{2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[11] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[12] = '{2'b00, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFB};

    n_rst = 1'b0; start = 1'b0; kill = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
    op = 2'b00; opa = '0; opb = '0; wdat = '0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    // Table, each op issued in the previous op's done cycle
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, 1'b1);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
      wait_done(1, $sformatf("v%0d", i));
    end
    tick();
    chk("done_single", 32'(done), 32'd0);

    // MTHI / MTLO
    hi_wen = 1'b1; wdat = 32'h1234;
    tick();
    hi_wen = 1'b0; lo_wen = 1'b1; wdat = 32'h5678;
    tick();
    lo_wen = 1'b0;
    chk("mthi", hi, 32'h1234);
    chk("mtlo", lo, 32'h5678);

    // Kill in cycle 10
    issue(2'b11, 32'd100, 32'd7, '0, '0, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    chk("kill_busy_before", 32'(busy), 32'd1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("kill_busy_after", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      tick();
    end
    chk("kill_no_done", 32'(seen), 32'd0);
    chk("kill_hi", hi, 32'h1234);
    chk("kill_lo", lo, 32'h5678);

    // Kill in IDLE blocks start but not the write
    start = 1'b1; kill = 1'b1; hi_wen = 1'b1; wdat = 32'hAAAA; op = 2'b01; opa = 32'd3; opb = 32'd5;
    tick();
    start = 1'b0; kill = 1'b0; hi_wen = 1'b0;
    chk("idle_kill_busy", 32'(busy), 32'd0);
    chk("idle_kill_hi", hi, 32'hAAAA);

    // Start and MTHI while busy are ignored
    issue(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    start = 1'b1; op = 2'b11; opa = 32'd100; opb = 32'd7; hi_wen = 1'b1; wdat = 32'hFFFF;
    tick();
    start = 1'b0; hi_wen = 1'b0;
    chk("busy_write_ignored", hi, 32'hAAAA);
    wait_done(6, "stall");

    // Write and start in the same IDLE cycle
    lo_wen = 1'b1; wdat = 32'hBEEF;
    issue(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1);
    lo_wen = 1'b0;
    chk("overlap_write", lo, 32'hBEEF);
    wait_done(1, "overlap");

    // Asynchronous reset mid-operation
    issue(2'b11, 32'd100, 32'd7, '0, '0, 1'b0);
    for (int i = 0; i < 19; i++) tick();
    #2;
    n_rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) seen++;
    end
    chk("arst_no_done", 32'(seen), 32'd0);
    issue(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    wait_done(1, "post_rst");

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit for the execute stage, directly downstream of the register file. It consumes the two register-file read operands, computes MIPS-style MULT/MULTU/DIV/DIVU results over a fixed 34-cycle sequence, and holds them in architectural HI/LO registers. MFHI/MFLO read HI/LO; MTHI/MTLO write them through a dedicated write port.

## Interface
- No parameters. Width is fixed at 32.
- clk  in  1  clock; all state updates on posedge.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- opa  in  32  rs operand (rdat1): multiplicand or dividend.
- opb  in  32  rt operand (rdat2): multiplier or divisor.
- kill  in  1  synchronous abort from a pipeline flush.
- hi_wen  in  1  MTHI write enable.
- lo_wen  in  1  MTLO write enable.
- wdat  in  32  MTHI/MTLO write data.
- busy  out  1  high while an operation is in flight; the pipeline stalls any MFHI/MFLO/MULT/DIV on it.
- done  out  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- hi  out  32  HI register (product[63:32] or remainder).
- lo  out  32  LO register (product[31:0] or quotient).

## Operation
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on start & !kill. Latch op, opa and opb; clear iteration counter `cnt` (5 bits).
  - RUN: one iteration per cycle for 32 cycles. Exit to FIX when cnt==31; cnt increments each RUN cycle.
  - FIX -> IDLE: apply sign correction, write HI/LO, set registered `done` for the following cycle.
- Signed ops operate on magnitudes. Record sa=opa[31] and sb=opb[31]; both are 0 for unsigned ops.
- Multiply uses shift-add on the 64-bit product of the magnitudes. If sa^sb, negate the 64-bit product in FIX. HI=product[63:32], LO=product[31:0].
- Divide uses restoring division (33-bit partial remainder) on the magnitudes.
  - Quotient is negated if sa^sb; the result truncates toward zero.
  - Remainder is negated if sa; the remainder takes the dividend's sign.
- Divide by zero (opb==0, any divide op): LO=32'hFFFFFFFF, HI=opa. Latency is unchanged.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude algorithm and needs no special case.
- busy = (state != IDLE). done is low except for the single cycle after FIX.
- MTHI/MTLO: while IDLE, hi_wen/lo_wen write wdat into hi/lo at the edge.
  - They are ignored while busy.
  - If a write and start occur in the same IDLE cycle, the write takes effect and the later result overwrites it.
- kill in RUN or FIX: next edge returns to IDLE. HI/LO are unchanged and no done pulse is produced.
- kill in IDLE overrides start: no operation begins, but MTHI/MTLO writes in that cycle still take effect.
- start while busy is ignored; the pipeline is required to stall instead.
- Reset values: state=IDLE, hi=0, lo=0, busy=0, done=0, cnt=0, internal datapath registers=0.

## Timing
- Cycle 0: start=1 in IDLE.
- Cycles 1-32: RUN, busy=1.
- Cycle 33: FIX, busy=1.
- Cycle 34: IDLE, busy=0, done=1, hi/lo valid.
- Start-to-done latency is 34 cycles for every op, including divide by zero.
- A new start is accepted in the done cycle (cycle 34), giving back-to-back throughput of one op per 34 cycles.
- Operands are latched at the cycle-0 edge. opa/opb may change afterwards without affecting the result.
- hi/lo change only at the FIX->IDLE edge, on MTHI/MTLO writes, or on reset. They never expose intermediate values.
- Asserting n_rst mid-operation forces the reset values immediately (asynchronous). No done is produced.

## Test plan
- MULT opa=0xFFFFFFFD (-3), opb=7 -> done exactly 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU opa=opb=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIV opa=0xFFFFFFF9 (-7), opb=2 issued in the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF 34 cycles later.
- DIVU opa=7, opb=0 -> lo=0xFFFFFFFF, hi=7. DIV opa=0x80000000, opb=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI wdat=0x1234 then MTLO wdat=0x5678 in IDLE -> hi=0x1234, lo=0x5678. DIVU 100/7 started; kill asserted in cycle 10 -> busy falls at the next edge, no done, hi/lo stay 0x1234/0x5678.
- Start MULTU 3*5, pulse start again plus hi_wen in cycle 5 -> both ignored; done at cycle 34 with hi=0, lo=15.
- Start DIVU 100/7; drop n_rst in cycle 20 -> immediately state IDLE, busy=0, hi=lo=0, no done. After release, DIVU 100/7 -> lo=14, hi=2.
